// File: rtl/adc_moving_avg_if.sv
// Sample stream in, averaged stream out, for the boxcar filter.
interface adc_moving_avg_if #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 3
);
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     clr;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_avg;
  logic [DATA_W+LOG2_N-1:0] out_sum;
  logic                     filled;

  modport master (
    output in_valid, in_data, clr,
    input  out_valid, out_avg, out_sum, filled
  );

  modport slave (
    input  in_valid, in_data, clr,
    output out_valid, out_avg, out_sum, filled
  );
endinterface

// File: rtl/adc_moving_avg.sv
// Boxcar moving-average filter over the last 2**LOG2_N ADC samples.
// Running sum is updated incrementally (sum + new - oldest) from a circular buffer.
module adc_moving_avg #(
  parameter int DATA_W      = 16,
  parameter int LOG2_N      = 3,
  parameter int ROUND       = 0,
  parameter int WARMUP_GATE = 0
) (
  input logic              clk,
  input logic              reset,
  adc_moving_avg_if.slave  bus
);
  localparam int N     = 1 << LOG2_N;
  localparam int SUM_W = DATA_W + LOG2_N;
  localparam logic [LOG2_N:0] N_CNT = (LOG2_N+1)'(N);
  localparam logic [SUM_W:0]  HALF  = (SUM_W+1)'(1) << (LOG2_N - 1);

  logic [DATA_W-1:0] mem_q [N];
  logic [LOG2_N-1:0] wp_q, wp_d;
  logic [LOG2_N:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              filled_q, filled_d;
  logic              acc_q, clr_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic [SUM_W-1:0]  osum_q;

  logic              accept;
  logic [DATA_W-1:0] oldest;
  logic [DATA_W:0]   rnd_avg;

  // Window bookkeeping: clr wins over a same-cycle sample.
  always_comb begin
    accept = bus.in_valid && !bus.clr;
    oldest = filled_q ? mem_q[wp_q] : '0;
    sum_d  = sum_q;
    wp_d   = wp_q;
    cnt_d  = cnt_q;
    if (bus.clr) begin
      sum_d = '0;
      wp_d  = '0;
      cnt_d = '0;
    end else if (accept) begin
      sum_d = sum_q + SUM_W'(bus.in_data) - SUM_W'(oldest);
      wp_d  = wp_q + LOG2_N'(1);
      if (cnt_q != N_CNT) cnt_d = cnt_q + (LOG2_N+1)'(1);
    end
    filled_d = (cnt_d == N_CNT);
  end

  // Average of the current sum, truncated or rounded half up with saturation.
  always_comb begin
    rnd_avg = (DATA_W+1)'(({1'b0, sum_q} + HALF) >> LOG2_N);
    if (ROUND != 0) avg_d = rnd_avg[DATA_W] ? '1 : rnd_avg[DATA_W-1:0];
    else            avg_d = DATA_W'(sum_q >> LOG2_N);
  end

  // Sample buffer; contents need no reset since the fill count masks stale slots.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wp_q] <= bus.in_data;
  end

  // Window state plus a one-cycle-late output stage fed from the registered sum.
  // A clr is also delayed one cycle so a sample accepted just before it still emits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q       <= '0;
      wp_q        <= '0;
      cnt_q       <= '0;
      filled_q    <= 1'b0;
      acc_q       <= 1'b0;
      clr_q       <= 1'b0;
      out_valid_q <= 1'b0;
      avg_q       <= '0;
      osum_q      <= '0;
    end else begin
      sum_q       <= sum_d;
      wp_q        <= wp_d;
      cnt_q       <= cnt_d;
      filled_q    <= filled_d;
      acc_q       <= accept;
      clr_q       <= bus.clr;
      out_valid_q <= acc_q && ((WARMUP_GATE == 0) || filled_q);
      if (acc_q || clr_q) begin
        osum_q <= sum_q;
        avg_q  <= avg_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_avg   = avg_q;
  assign bus.out_sum   = osum_q;
  assign bus.filled    = filled_q;
endmodule

// File: tb/tb_adc_moving_avg.sv
// Bench for adc_moving_avg: three configurations driven with identical stimulus
// (truncate, round, warm-up gated) against a queue-based window model.
module tb_adc_moving_avg;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  adc_moving_avg_if #(.DATA_W(16), .LOG2_N(3)) a0 ();
  adc_moving_avg_if #(.DATA_W(16), .LOG2_N(3)) a1 ();
  adc_moving_avg_if #(.DATA_W(16), .LOG2_N(3)) a2 ();

  adc_moving_avg #(.DATA_W(16), .LOG2_N(3), .ROUND(0), .WARMUP_GATE(0)) d0 (
    .clk(clk), .reset(rst_n), .bus(a0));
  adc_moving_avg #(.DATA_W(16), .LOG2_N(3), .ROUND(1), .WARMUP_GATE(0)) d1 (
    .clk(clk), .reset(rst_n), .bus(a1));
  adc_moving_avg #(.DATA_W(16), .LOG2_N(3), .ROUND(0), .WARMUP_GATE(1)) d2 (
    .clk(clk), .reset(rst_n), .bus(a2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: window = last up-to-8 samples since reset/clr; outputs
  // show the window as it stood after the previous edge's event.
  int unsigned q[$];
  bit          ev_acc, ev_clr, ev_full;
  int unsigned wsum;
  int unsigned e_sum, e_avg_t, e_avg_r;
  bit          e_v, e_vg, e_fill;

  initial begin
    ev_acc = 0; ev_clr = 0; ev_full = 0; wsum = 0;
    e_sum = 0; e_avg_t = 0; e_avg_r = 0; e_v = 0; e_vg = 0; e_fill = 0;
  end

  always begin
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      ev_acc = 0; ev_clr = 0; ev_full = 0; wsum = 0;
      e_sum = 0; e_avg_t = 0; e_avg_r = 0; e_v = 0; e_vg = 0; e_fill = 0;
    end else begin
      e_v  = ev_acc;
      e_vg = ev_acc && ev_full;
      if (ev_acc || ev_clr) begin
        e_sum   = wsum;
        e_avg_t = wsum / 8;
        e_avg_r = (wsum + 4) / 8;
        if (e_avg_r > 65535) e_avg_r = 65535;
      end
      ev_acc = 0;
      ev_clr = 0;
      if (a0.clr) begin
        q.delete();
        ev_clr = 1;
      end else if (a0.in_valid) begin
        q.push_back(int'(a0.in_data));
        if (q.size() > 8) void'(q.pop_front());
        ev_acc = 1;
      end
      wsum = 0;
      foreach (q[i]) wsum += q[i];
      e_fill  = (q.size() == 8);
      ev_full = e_fill;
    end
    #1;
    chk("d0.valid",  a0.out_valid, e_v);
    chk("d0.sum",    a0.out_sum,   e_sum);
    chk("d0.avg",    a0.out_avg,   e_avg_t);
    chk("d0.filled", a0.filled,    e_fill);
    chk("d1.valid",  a1.out_valid, e_v);
    chk("d1.sum",    a1.out_sum,   e_sum);
    chk("d1.avg",    a1.out_avg,   e_avg_r);
    chk("d1.filled", a1.filled,    e_fill);
    chk("d2.valid",  a2.out_valid, e_vg);
    chk("d2.sum",    a2.out_sum,   e_sum);
    chk("d2.avg",    a2.out_avg,   e_avg_t);
    chk("d2.filled", a2.filled,    e_fill);
  end

  task automatic drive(input bit v, input bit c, input int unsigned d);
    @(negedge clk);
    a0.in_valid = v; a0.clr = c; a0.in_data = 16'(d);
    a1.in_valid = v; a1.clr = c; a1.in_data = 16'(d);
    a2.in_valid = v; a2.clr = c; a2.in_data = 16'(d);
  endtask

  task automatic push(input int unsigned d);
    drive(1'b1, 1'b0, d);
  endtask

  task automatic flush();
    drive(1'b0, 1'b1, 0);
  endtask

  // Stop driving, then land just after the edge that presents the last sample.
  task automatic settle();
    drive(1'b0, 1'b0, 0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a0.in_valid = 0; a0.clr = 0; a0.in_data = '0;
    a1.in_valid = 0; a1.clr = 0; a1.in_data = '0;
    a2.in_valid = 0; a2.clr = 0; a2.in_data = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst.valid",  a0.out_valid, 0);
    chk("rst.sum",    a0.out_sum,   0);
    chk("rst.avg",    a0.out_avg,   0);
    chk("rst.filled", a0.filled,    0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single sample: latency 1, unfilled slots count as zero.
    push(800);
    settle();
    chk("t1.valid",  a0.out_valid, 1);
    chk("t1.sum",    a0.out_sum,   800);
    chk("t1.avg",    a0.out_avg,   100);
    chk("t1.filled", a0.filled,    0);

    // Fill with 100s, then displace the oldest with 900.
    flush();
    for (int i = 0; i < 8; i++) push(100);
    settle();
    chk("t2.avg",    a0.out_avg, 100);
    chk("t2.sum",    a0.out_sum, 800);
    chk("t2.filled", a0.filled,  1);
    push(900);
    settle();
    chk("t2.sum9", a0.out_sum, 1600);
    chk("t2.avg9", a0.out_avg, 200);

    // Full-scale burst: widest sum, rounding clamps at full scale.
    for (int i = 0; i < 16; i++) push(16'hFFFF);
    settle();
    chk("t3.sum",    a0.out_sum, 32'h7FFF8);
    chk("t3.avg",    a0.out_avg, 16'hFFFF);
    chk("t3.ravg",   a1.out_avg, 16'hFFFF);
    for (int i = 0; i < 8; i++) push(0);
    settle();
    chk("t3.avg0", a0.out_avg, 0);
    chk("t3.sum0", a0.out_sum, 0);

    // Round half up vs truncate.
    flush();
    push(12);
    for (int i = 0; i < 7; i++) push(0);
    settle();
    chk("t4.tavg", a0.out_avg, 1);
    chk("t4.ravg", a1.out_avg, 2);

    // Warm-up gating on d2.
    flush();
    for (int i = 0; i < 7; i++) push(5);
    settle();
    chk("t5.gate7", a2.out_valid, 0);
    chk("t5.sum7",  a2.out_sum,   35);
    push(5);
    settle();
    chk("t5.gate8", a2.out_valid, 1);
    chk("t5.fill8", a2.filled,    1);
    drive(1'b1, 1'b1, 77);
    settle();
    chk("t5.clr.filled", a2.filled,    0);
    chk("t5.clr.sum",    a2.out_sum,   0);
    chk("t5.clr.valid",  a2.out_valid, 0);

    // A sample accepted the cycle before clr still emits.
    push(33);
    drive(1'b0, 1'b1, 0);
    @(posedge clk);
    #2;
    chk("t5.pend.valid", a0.out_valid, 1);
    chk("t5.pend.sum",   a0.out_sum,   33);
    settle();
    chk("t5.pend.sum0", a0.out_sum, 0);

    // Reset mid-stream clears outputs without waiting for a clock edge.
    for (int i = 0; i < 5; i++) push(9);
    @(negedge clk);
    a0.in_valid = 0; a1.in_valid = 0; a2.in_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("t6.rst.sum",    a0.out_sum,   0);
    chk("t6.rst.avg",    a0.out_avg,   0);
    chk("t6.rst.valid",  a0.out_valid, 0);
    chk("t6.rst.filled", a0.filled,    0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) push(40);
    settle();
    chk("t6.avg",    a0.out_avg,   40);
    chk("t6.sum",    a0.out_sum,   320);
    chk("t6.filled", a0.filled,    1);
    chk("t6.gvalid", a2.out_valid, 1);

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
